// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter: two operand requesters and one
// tagged result consumer. The arbiter connects through the slave modport.
interface addsub_arbiter_if #(
    parameter int WIDTH = 16
);
    // Valid/ready: a transfer happens on a rising clk edge where valid and ready
    // are both 1. Valid must not depend on ready; ready may depend on valid.
    // An unaccepted request may change or drop; the response holds until taken.
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req0_pad;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             req1_pad;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_pad,
        output req1_valid, req1_a, req1_b, req1_sub, req1_pad,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_pad,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_pad,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_err
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one saturating 16-bit add/subtract unit.
// Round-robin by default; define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module addsub_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_arbiter_if.slave   bus,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             pad_q;
    logic             id_q;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] result;
    logic             ovf;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
    logic             last_grant;
`endif

    always_comb begin
        grant = 1'b0;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
        grant = !bus.req0_valid;
`else
        // On a tie the requester that did not win last time is served.
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
        else                                  grant = !bus.req0_valid;
`endif
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant && rst_n;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant && rst_n;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign state_dbg      = state;

    // Subtraction is A + ~B + 1; overflow when the effective operand signs agree
    // and the result sign differs.
    always_comb begin
        b_eff  = sub_q ? ~b_q : b_q;
        raw    = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
        ovf    = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
        result = raw;
        if (pad_q && ovf)
            result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            sub_q         <= 1'b0;
            pad_q         <= 1'b0;
            id_q          <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_err   <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= grant ? bus.req1_a   : bus.req0_a;
                        b_q   <= grant ? bus.req1_b   : bus.req0_b;
                        sub_q <= grant ? bus.req1_sub : bus.req0_sub;
                        pad_q <= grant ? bus.req1_pad : bus.req0_pad;
                        id_q  <= grant;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    bus.rsp_sum   <= result;
                    bus.rsp_err   <= ovf;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed cases plus randomized traffic checked every
// cycle against an arithmetic reference model and an expected-response queue.
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy;
  logic [1:0] state_dbg;

  addsub_arbiter_if #(.WIDTH(16)) bus();

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  int          m_phase = 0;   // 0 idle, 1 computing, 2 response held
  logic        m_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {id, err, sum} computed with full-precision integer arithmetic.
  function automatic logic [17:0] ref_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic pad);
    int          sa, sb, r;
    logic [31:0] rv;
    logic        ovf;
    logic [15:0] s;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = sub ? sa - sb : sa + sb;
    ovf = (r > 32767) || (r < -32768);
    rv  = r;
    s   = rv[15:0];
    if (ovf && pad) s = (r > 0) ? 16'h7FFF : 16'h8000;
    return {id, ovf, s};
  endfunction

  // Compare process: checks DUT against the model, then advances the model.
  always @(negedge clk) begin : cmp
    logic g, e0, e1;
    if (!rst_n) begin
      check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
      check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      m_phase = 0;
      m_last  = 1'b1;
    end else begin
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      if (bus.req0_valid && bus.req1_valid) g = 1'b0;
`else
      if (bus.req0_valid && bus.req1_valid) g = ~m_last;
`endif
      else g = !bus.req0_valid;
      e0 = (m_phase == 0) && bus.req0_valid && !g;
      e1 = (m_phase == 0) && bus.req1_valid && g;
      check("req0_ready", 32'(bus.req0_ready), 32'(e0));
      check("req1_ready", 32'(bus.req1_ready), 32'(e1));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        if (exp_q.size() == 0) check("exp_q_empty", 32'd0, 32'd1);
        else check("rsp_fields", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_sum}), 32'(exp_q[0]));
      end
      case (m_phase)
        0: if (e0 || e1) begin
          exp_q.push_back(g ? ref_op(1'b1, bus.req1_a, bus.req1_b, bus.req1_sub, bus.req1_pad)
                            : ref_op(1'b0, bus.req0_a, bus.req0_b, bus.req0_sub, bus.req0_pad));
          m_last  = g;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic pad);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_pad = pad;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_pad = pad;
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Submit one request, wait for its acceptance and response; returns the
  // response fields and the number of falling edges from accept to rsp_valid.
  task automatic do_single(input int n, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic pad,
                           output logic [17:0] got, output int lat);
    logic ok;
    tick();
    set_req(n, 1'b1, a, b, sub, pad);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    set_req(n, 1'b0, a, b, sub, pad);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    check("rsp_timeout", 32'(ok), 32'd1);
    got = {bus.rsp_id, bus.rsp_err, bus.rsp_sum};
  endtask

  task automatic wait_rsp(output logic [17:0] got);
    logic ok;
    ok = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    check("wait_rsp_timeout", 32'(ok), 32'd1);
    got = {bus.rsp_id, bus.rsp_err, bus.rsp_sum};
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    logic [17:0] got, got2;
    int          lat;
    logic        idv;

    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.rsp_ready = 1'b1;

    // Pin the reference model on hand-computed values.
    check("ref_pos_sat", 32'(ref_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1)), 32'h17FFF);
    check("ref_sub_wrap", 32'(ref_op(1'b1, 16'h8800, 16'h0900, 1'b1, 1'b0)), 32'h37F00);
    check("ref_neg_sat", 32'(ref_op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b1)), 32'h18000);
    check("ref_plain_sub", 32'(ref_op(1'b0, 16'h0005, 16'h0003, 1'b1, 1'b0)), 32'h00002);

    // Reset with both requesters valid.
    #2;
    rst_n = 1'b0;
    set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    set_req(1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("reset_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("reset_rsp_sum", 32'(bus.rsp_sum), 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Saturating positive overflow with latency check.
    do_single(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, got, lat);
    check("sat_latency", 32'(lat), 32'd2);
    check("sat_rsp", 32'(got), 32'h17FFF);

    // Tie after reset: requester 0 first, then requester 1.
    do_reset();
    set_req(0, 1'b1, 16'h1234, 16'h0001, 1'b0, 1'b0);
    set_req(1, 1'b1, 16'h8800, 16'h0900, 1'b1, 1'b0);
    wait_rsp(got);
    check("tie_first", 32'(got), 32'h01235);
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_rsp(got2);
    check("tie_second", 32'(got2), 32'h37F00);
    tick();
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Backpressure: response held while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    do_single(0, 16'h4000, 16'h4000, 1'b0, 1'b0, got, lat);
    check("bp_rsp", 32'(got), 32'h18000);
    tick();
    set_req(0, 1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0);
    set_req(1, 1'b1, 16'h0506, 16'h0708, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_fields", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_sum}), 32'(got));
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
      check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_still_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset pulsed while the operation is in CALC.
    tick();
    set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    idv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin idv = 1'b1; break; end
    end
    check("midop_accept", 32'(idv), 32'd1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midop_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    do_single(0, 16'h0000, 16'h0000, 1'b0, 1'b0, got, lat);
    check("midop_next", 32'(got), 32'h00000);

    // Six back-to-back operations with both requesters valid.
    do_reset();
    set_req(0, 1'b1, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    set_req(1, 1'b1, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) begin
      idv = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (bus.rsp_valid) begin idv = 1'b1; break; end
      end
      check("seq_rsp_timeout", 32'(idv), 32'd1);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      check("seq_id", 32'(bus.rsp_id), 32'd0);
`else
      check("seq_id", 32'(bus.rsp_id), 32'(i % 2));
`endif
      @(posedge clk);
    end
    #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Randomized traffic; every cycle is checked by the compare process.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      set_req(0, ($urandom_range(0, 9) < 6), pick_operand(), pick_operand(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_req(1, ($urandom_range(0, 9) < 6), pick_operand(), pick_operand(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("drain_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
